// File: rtl/if_fetch_unit_pkg.sv
// Types and constants shared by the instruction-fetch unit and its IF/ID register.
// The unit honours the optional build macro IF_MISALIGN_TRAP_EN (misaligned redirect trap).
package if_fetch_unit_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
    localparam logic                   CHIP_ENABLE      = 1'b1;
    localparam logic                   CHIP_DISABLE     = 1'b0;
    localparam logic [INST_ADDR_W-1:0] START_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'b00,
        FETCH_RUN  = 2'b01,
        FETCH_HOLD = 2'b10
    } fetch_state_e;

    function automatic logic addr_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_id_reg.sv
// IF/ID pipeline register: kill (forced bubble) beats hold, hold beats bubble, otherwise capture.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill_i,
    input  logic            hold_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            id_valid_o
);

    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_inst_q;
    logic            id_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_q    <= '0;
            id_inst_q  <= XLEN'(ZERO_WORD);
            id_valid_q <= 1'b0;
        end else if (kill_i) begin
            id_pc_q    <= '0;
            id_inst_q  <= XLEN'(ZERO_WORD);
            id_valid_q <= 1'b0;
        end else if (hold_i) begin
            id_pc_q    <= id_pc_q;
            id_inst_q  <= id_inst_q;
            id_valid_q <= id_valid_q;
        end else if (bubble_i) begin
            id_pc_q    <= '0;
            id_inst_q  <= XLEN'(ZERO_WORD);
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= pc_i;
            id_inst_q  <= inst_i;
            id_valid_q <= 1'b1;
        end
    end

    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: PC, boot/run/hold FSM, stalled-branch redirect buffering, ROM drive.
// Build macro IF_MISALIGN_TRAP_EN: refuse redirects to non-word targets and pulse misalign_exc_o.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] START_PC = START_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            branch_flag_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            rom_ce_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic [XLEN-1:0] rom_inst_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            id_valid_o,
    output logic            misalign_exc_o
);

    fetch_state_e    state_q;
    logic            ce_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] redir_pc;
    logic            redir_req;
    logic            redir_bad;
    logic            pend_apply;
    logic            booting;

    assign booting = (state_q == FETCH_BOOT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_BOOT;
            ce_q    <= CHIP_DISABLE;
        end else begin
            ce_q <= CHIP_ENABLE;
            if (flush_i) begin
                state_q <= FETCH_RUN;
            end else begin
                case (state_q)
                    FETCH_BOOT: state_q <= FETCH_RUN;
                    FETCH_RUN:  if (stall_i[0])  state_q <= FETCH_HOLD;
                    FETCH_HOLD: if (!stall_i[0]) state_q <= FETCH_RUN;
                    default:    state_q <= FETCH_BOOT;
                endcase
            end
        end
    end

    // A branch seen while the PC is frozen is parked and replayed on the first unstalled edge.
    always_comb begin
        redir_req    = 1'b0;
        redir_pc     = pc_q;
        pend_apply   = 1'b0;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        if (flush_i) begin
            redir_req = 1'b1;
            redir_pc  = flush_pc_i;
            pending_d = 1'b0;
        end else if (branch_flag_i) begin
            if (stall_i[0]) begin
                pending_d    = 1'b1;
                pending_pc_d = branch_target_i;
            end else begin
                redir_req = 1'b1;
                redir_pc  = branch_target_i;
                pending_d = 1'b0;
            end
        end else if (pending_q && !stall_i[0]) begin
            redir_req  = 1'b1;
            redir_pc   = pending_pc_q;
            pend_apply = 1'b1;
            pending_d  = 1'b0;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    assign redir_bad = redir_req && addr_misaligned(redir_pc[1:0]);
`else
    assign redir_bad = 1'b0;
`endif

    always_comb begin
        if (redir_req && !redir_bad) begin
            pc_d = redir_pc;
        end else if (redir_req || stall_i[0] || booting) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= START_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic exc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= redir_bad;
        end
    end

    assign misalign_exc_o = exc_q;
`else
    assign misalign_exc_o = 1'b0;
`endif

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q;

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .kill_i     (flush_i | booting),
        .hold_i     (stall_i[1]),
        .bubble_i   (branch_flag_i | pend_apply | stall_i[0] | redir_bad),
        .pc_i       (pc_q),
        .inst_i     (rom_inst_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random stall/branch/flush/reset traffic,
// checked against a rule-level fetch model with its own instruction memory.
module tb_if_fetch_unit;

`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        misalign_exc_o;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc, m_pend_pc, m_id_pc, m_id_inst;
    logic        m_boot, m_pend, m_id_valid, m_exc;

    if_fetch_unit #(
        .XLEN     (32),
        .START_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .misalign_exc_o  (misalign_exc_o)
    );

    assign rom_inst_i = mem[rom_addr_o[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0; m_boot = 1'b1;
        m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_exc = 1'b0;
    endtask

    task automatic check_id(input string tag);
        chk({tag, ".id_pc"}, id_pc_o, m_id_pc);
        chk({tag, ".id_inst"}, id_inst_o, m_id_inst);
        chk({tag, ".id_valid"}, 32'(id_valid_o), 32'(m_id_valid));
        chk({tag, ".exc"}, 32'(misalign_exc_o), 32'(m_exc));
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b0;
        stall_i = 2'b00; flush_i = 1'b0; branch_flag_i = 1'b0;
        flush_pc_i = 32'h0; branch_target_i = 32'h0;
        #1;
        model_reset();
        chk("rst.ce", 32'(rom_ce_o), 32'h0);
        chk("rst.addr", rom_addr_o, 32'h0);
        check_id("rst");
        #2;
        rst = 1'b1;
    endtask

    // One clock of stimulus: check fetch outputs, advance the model by the fetch rules, check IF/ID.
    task automatic cycle(input logic [1:0] s, input logic fl, input logic [31:0] fpc,
                         input logic br, input logic [31:0] btgt);
        logic        want_redir, applied, bad;
        logic [31:0] want_pc, n_pc;
        stall_i = s; flush_i = fl; flush_pc_i = fpc;
        branch_flag_i = br; branch_target_i = btgt;
        #1;
        chk("ce", 32'(rom_ce_o), m_boot ? 32'h0 : 32'h1);
        chk("addr", rom_addr_o, m_pc);
        want_redir = 1'b0; applied = 1'b0; want_pc = 32'h0;
        if (fl) begin
            want_redir = 1'b1; want_pc = fpc; m_pend = 1'b0;
        end else if (br && s[0]) begin
            m_pend = 1'b1; m_pend_pc = btgt;
        end else if (br) begin
            want_redir = 1'b1; want_pc = btgt; m_pend = 1'b0;
        end else if (m_pend && !s[0]) begin
            want_redir = 1'b1; want_pc = m_pend_pc; m_pend = 1'b0; applied = 1'b1;
        end
        bad = TRAP && want_redir && (want_pc % 4 != 0);
        if (want_redir && !bad)               n_pc = want_pc;
        else if (want_redir || s[0] || m_boot) n_pc = m_pc;
        else                                   n_pc = m_pc + 32'd4;
        if (fl || m_boot || (!s[1] && (br || applied || s[0] || bad))) begin
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        end else if (!s[1]) begin
            m_id_pc = m_pc; m_id_inst = mem[m_pc[9:2]]; m_id_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_exc = bad; m_boot = 1'b0;
        check_id("cyc");
        $display("cyc t=%0t stall=%b fl=%b br=%b tgt=%h addr=%h id_pc=%h v=%b exc=%b",
                 $time, s, fl, br, fl ? fpc : btgt, rom_addr_o, id_pc_o, id_valid_o, misalign_exc_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [1:0]  rs;
        logic        rf, rb;
        logic [31:0] rt;
        int          seen8;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b0;
        stall_i = 2'b00; flush_i = 1'b0; branch_flag_i = 1'b0;
        flush_pc_i = 32'h0; branch_target_i = 32'h0;
        #12;
        model_reset();
        chk("reset.ce", 32'(rom_ce_o), 32'h0);
        chk("reset.addr", rom_addr_o, 32'h0);
        check_id("reset");
        rst = 1'b1;

        // boot: ce low one cycle, first valid instruction two edges after release
        idle(1);
        chk("boot.valid_early", 32'(id_valid_o), 32'h0);
        idle(1);
        chk("boot.first_pc", id_pc_o, 32'h0);
        chk("boot.first_inst", id_inst_o, mem[0]);
        chk("boot.first_valid", 32'(id_valid_o), 32'h1);
        idle(1);
        chk("seq.addr8", rom_addr_o, 32'h8);

        // full stall at pc=8 for three cycles, then 8 must be emitted exactly once
        for (int i = 0; i < 3; i++) begin
            cycle(2'b11, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("stall.addr", rom_addr_o, 32'h8);
            chk("stall.id_pc", id_pc_o, 32'h4);
        end
        seen8 = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (id_valid_o && id_pc_o == 32'h8) seen8++;
        end
        chk("stall.emit8_once", 32'(seen8), 32'd1);

        // now pc=0x14; redirect to 0x10 then branch from 0x10 to 0x40
        cycle(2'b00, 1'b1, 32'h10, 1'b0, 32'h0);
        chk("flush10.addr", rom_addr_o, 32'h10);
        cycle(2'b00, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("br.addr", rom_addr_o, 32'h40);
        chk("br.bubble", 32'(id_valid_o), 32'h0);
        idle(1);
        chk("br.id_pc", id_pc_o, 32'h40);

        // two branches during one PC stall: the later one wins, 0x80 never fetched
        cycle(2'b01, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("pend.hold1", rom_addr_o, 32'h44);
        cycle(2'b01, 1'b0, 32'h0, 1'b1, 32'h90);
        chk("pend.hold2", rom_addr_o, 32'h44);
        cycle(2'b01, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1);
        chk("pend.applied", rom_addr_o, 32'h90);
        chk("pend.bubble", 32'(id_valid_o), 32'h0);
        idle(1);
        chk("pend.id_pc", id_pc_o, 32'h90);

        // flush while a redirect is parked clears it
        cycle(2'b01, 1'b0, 32'h0, 1'b1, 32'hA0);
        cycle(2'b01, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("flush.addr", rom_addr_o, 32'h100);
        chk("flush.bubble", 32'(id_valid_o), 32'h0);
        idle(1);
        chk("flush.no_pending", rom_addr_o, 32'h104);

        // misaligned branch target
        cycle(2'b00, 1'b0, 32'h0, 1'b1, 32'h42);
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis.addr", rom_addr_o, 32'h104);
        chk("mis.exc", 32'(misalign_exc_o), 32'h1);
`else
        chk("mis.addr", rom_addr_o, 32'h42);
        chk("mis.exc", 32'(misalign_exc_o), 32'h0);
`endif
        idle(1);
        chk("mis.exc_pulse", 32'(misalign_exc_o), 32'h0);

        // PC wraps modulo 2^32
        cycle(2'b00, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle(1);
        chk("wrap.addr", rom_addr_o, 32'h0);
        chk("wrap.id_pc", id_pc_o, 32'hFFFF_FFFC);

        // reset in the middle of a parked redirect
        cycle(2'b01, 1'b0, 32'h0, 1'b1, 32'h200);
        do_reset();
        idle(3);
        chk("rst_pend.addr", rom_addr_o, 32'h8);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                rs[0] = ($urandom_range(0, 3) == 0);
                rs[1] = ($urandom_range(0, 4) == 0);
                rf    = ($urandom_range(0, 19) == 0);
                rb    = ($urandom_range(0, 6) == 0);
                rt    = 32'($urandom_range(0, 255)) << 2;
                if ($urandom_range(0, 7) == 0) rt[1:0] = 2'($urandom_range(1, 3));
                cycle(rs, rf, rt ^ 32'h200, rb, rt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
